// File: rtl/rrp_pkg.sv
// Shared types and sizing helpers for the radix-r multiplier request scheduler.
package rrp_pkg;

    // Widest requester ID a tag can carry; the scheduler uses the low id_bits(NREQ) bits.
    localparam int unsigned TAG_IDW = 8;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic int unsigned digit_bits(input int unsigned radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int unsigned id_bits(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rrp_rsp_fifo.sv
// Show-ahead response FIFO with occupancy count; head data reads as zero while empty.
module rrp_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign valid = (count_q != '0);
    assign pop   = rd_en && valid;
    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign push  = wr_en && ((count_q != CW'(DEPTH)) || pop);

    assign count   = count_q;
    assign rd_data = valid ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/rrp_mult_sched.sv
// Round-robin scheduler feeding one non-stallable pipelined multiplier through a credit-guarded
// response FIFO. Define RRP_SCHED_STATS_EN to add the issue_cnt/stall_cnt statistics outputs.
module rrp_mult_sched
    import rrp_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned RADIX      = 4,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MULT_LAT   = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NREQ-1:0]                             req_valid,
    output logic [NREQ-1:0]                             req_ready,
    input  logic [NREQ*digit_bits(RADIX)*WIDTH-1:0]     req_x,
    input  logic [NREQ*digit_bits(RADIX)*WIDTH-1:0]     req_y,
    output logic [digit_bits(RADIX)*WIDTH-1:0]          mx,
    output logic [digit_bits(RADIX)*WIDTH-1:0]          my,
    input  logic [digit_bits(RADIX)*(2*WIDTH+1)-1:0]    mp,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [id_bits(NREQ)-1:0]                    rsp_id,
    output logic [digit_bits(RADIX)*(2*WIDTH+1)-1:0]    rsp_p
`ifdef RRP_SCHED_STATS_EN
    ,
    output logic [31:0]                                 issue_cnt,
    output logic [31:0]                                 stall_cnt
`endif
);

    localparam int unsigned D   = digit_bits(RADIX);
    localparam int unsigned OW  = D * WIDTH;
    localparam int unsigned PW  = D * (2 * WIDTH + 1);
    localparam int unsigned IDW = id_bits(NREQ);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     rr_ptr_d;
    logic [IDW-1:0]     grant;
    logic               grant_valid;
    logic               issue;
    logic               pop;
    logic [CW-1:0]      credit_q;
    logic [OW-1:0]      x_sel;
    logic [OW-1:0]      y_sel;
    tag_t               tag_d;
    // Stage 0 is aligned with mx/my, so stage MULT_LAT is aligned with mp.
    tag_t               tag_q [MULT_LAT+1];
    logic [IDW+PW-1:0]  fifo_rd;
    logic [CW-1:0]      fifo_count;
    logic               unused_sink;

    // The candidate closest above rr_ptr (with wrap) is visited last and so wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && (((int'(rr_ptr_q) + k) % int'(NREQ)) == i)) begin
                    grant       = IDW'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign issue = grant_valid && (credit_q != '0) && !reset;
    assign pop   = rsp_valid && rsp_ready;

    always_comb begin
        req_ready = '0;
        x_sel     = '0;
        y_sel     = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant == IDW'(i)) begin
                x_sel = req_x[i*OW +: OW];
                y_sel = req_y[i*OW +: OW];
                req_ready[i] = issue;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        tag_d.valid = issue;
        tag_d.id    = TAG_IDW'(grant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            mx       <= '0;
            my       <= '0;
            credit_q <= CW'(FIFO_DEPTH);
        end else begin
            if (issue) begin
                rr_ptr_q <= rr_ptr_d;
                mx       <= x_sel;
                my       <= y_sel;
            end else begin
                mx <= '0;
                my <= '0;
            end
            // Credit counts free FIFO slots not already promised to in-flight products.
            if (issue && !pop) begin
                credit_q <= credit_q - 1'b1;
            end else if (!issue && pop) begin
                credit_q <= credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= int'(MULT_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= int'(MULT_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    rrp_rsp_fifo #(
        .WIDTH (IDW + PW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (tag_q[MULT_LAT].valid),
        .wr_data ({tag_q[MULT_LAT].id[IDW-1:0], mp}),
        .rd_en   (rsp_ready),
        .rd_data (fifo_rd),
        .valid   (rsp_valid),
        .count   (fifo_count)
    );

    assign rsp_id = fifo_rd[PW +: IDW];
    assign rsp_p  = fifo_rd[PW-1:0];

    assign unused_sink = ^{fifo_count, tag_q[MULT_LAT].id};

`ifdef RRP_SCHED_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if ((|req_valid) && (credit_q == '0)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rrp_mult_sched.sv
// Directed self-checking bench for rrp_mult_sched with a behavioural 8-cycle multiplier model.
module tb_rrp_mult_sched;

    localparam int unsigned WIDTH      = 4;
    localparam int unsigned RADIX      = 4;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned MULT_LAT   = 8;
    localparam int unsigned FIFO_DEPTH = 9;
    localparam int unsigned OW         = 12;
    localparam int unsigned PW         = 27;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*OW-1:0] req_x = '0;
    logic [NREQ*OW-1:0] req_y = '0;
    logic [OW-1:0]     mx;
    logic [OW-1:0]     my;
    logic [PW-1:0]     mp;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [PW-1:0]     rsp_p;
`ifdef RRP_SCHED_STATS_EN
    logic [31:0]       issue_cnt;
    logic [31:0]       stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    rrp_mult_sched #(
        .WIDTH      (WIDTH),
        .RADIX      (RADIX),
        .NREQ       (NREQ),
        .MULT_LAT   (MULT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mx        (mx),
        .my        (my),
        .mp        (mp),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
`ifdef RRP_SCHED_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Multiplier model: not reset, so stale products keep flowing after a scheduler reset.
    logic signed [PW-1:0] mpipe [MULT_LAT];
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] ys;
    assign xs = {{(PW-OW){mx[OW-1]}}, mx};
    assign ys = {{(PW-OW){my[OW-1]}}, my};
    assign mp = mpipe[MULT_LAT-1];

    always_ff @(posedge clock) begin
        mpipe[0] <= xs * ys;
        for (int k = 1; k < int'(MULT_LAT); k++) begin
            mpipe[k] <= mpipe[k-1];
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        req_x[i*OW +: OW] = OW'(x);
        req_y[i*OW +: OW] = OW'(y);
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = '1;
        tick;
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_p !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b id=%0d p=%0h want 0/0/0", rsp_valid, rsp_id, rsp_p);
        end
        n_tests++;
        if (mx !== '0 || my !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got mx=%0h my=%0h want 0/0", mx, my);
        end
        reset     = 1'b0;
        req_valid = '0;
        tick;
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 0000", req_ready);
        end
    endtask

    task automatic test_single;
        bit early;
        set_op(0, 3, 5);
        req_valid = 4'b0001;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        tick;
        req_valid = '0;
        n_tests++;
        if (mx !== 12'd3 || my !== 12'd5) begin
            n_fail++;
            $display("FAIL single_operands: got mx=%0d my=%0d want 3/5", mx, my);
        end
        tick;
        n_tests++;
        if (mx !== '0 || my !== '0) begin
            n_fail++;
            $display("FAIL idle_operands: got mx=%0h my=%0h want 0/0", mx, my);
        end
        early = 1'b0;
        for (int k = 2; k < 10; k++) begin
            if (rsp_valid !== 1'b0) early = 1'b1;
            tick;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL single_early: got rsp_valid before latency want none");
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== PW'(15)) begin
            n_fail++;
            $display("FAIL single_rsp: got valid=%b id=%0d p=%0d want 1/0/15", rsp_valid, rsp_id, rsp_p);
        end
        tick;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_once: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int waited;
        logic [3:0] want;
        do_reset;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            want = 4'b0001 << (k % 4);
            n_tests++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, want);
            end
            tick;
        end
        req_valid = '0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        n_tests++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL rr_latency: got wait=%0d want 2", waited);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_p !== PW'(2 * (k % 4 + 1))) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got valid=%b id=%0d p=%0d want 1/%0d/%0d",
                         k, rsp_valid, rsp_id, rsp_p, k % 4, 2 * (k % 4 + 1));
            end
            tick;
        end
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_tail: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        int issued;
        int got;
        bit bad_onehot;
        logic [19:0] seen;
        do_reset;
        rsp_ready  = 1'b0;
        issued     = 0;
        bad_onehot = 1'b0;
        seen       = '0;
        for (int t = 0; t < 20; t++) begin
            set_op(1, issued + 1, 3);
            req_valid = 4'b0010;
            #1;
            seen[t] = (req_ready == 4'b0010);
            if (req_ready !== 4'b0010 && req_ready !== 4'b0000) bad_onehot = 1'b1;
            if (req_ready[1] === 1'b1) issued++;
            tick;
        end
        n_tests++;
        if (issued !== 9 || seen !== 20'h001FF) begin
            n_fail++;
            $display("FAIL bp_stall: got issues=%0d pattern=%h want 9/001ff", issued, seen);
        end
        n_tests++;
        if (bad_onehot) begin
            n_fail++;
            $display("FAIL bp_onehot: got non-one-hot ready want one-hot or zero");
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== PW'(3)) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b id=%0d p=%0d want 1/1/3", rsp_valid, rsp_id, rsp_p);
        end
`ifdef RRP_SCHED_STATS_EN
        n_tests++;
        if (issue_cnt !== 32'd9 || stall_cnt !== 32'd11) begin
            n_fail++;
            $display("FAIL stats: got issue=%0d stall=%0d want 9/11", issue_cnt, stall_cnt);
        end
`endif
        rsp_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 60 && got < 12; t++) begin
            set_op(1, issued + 1, 3);
            req_valid = (issued < 12) ? 4'b0010 : 4'b0000;
            #1;
            if (rsp_valid === 1'b1) begin
                n_tests++;
                if (rsp_id !== 2'd1 || rsp_p !== PW'(3 * (got + 1))) begin
                    n_fail++;
                    $display("FAIL bp_drain%0d: got id=%0d p=%0d want 1/%0d", got, rsp_id, rsp_p, 3 * (got + 1));
                end
                got++;
            end
            if (req_ready[1] === 1'b1) issued++;
            tick;
        end
        req_valid = '0;
        n_tests++;
        if (got !== 12 || issued !== 12) begin
            n_fail++;
            $display("FAIL bp_count: got rsp=%0d issues=%0d want 12/12", got, issued);
        end
    endtask

    task automatic test_credit_one;
        int issued;
        int got;
        logic [21:0] seen;
        logic [21:0] want;
        do_reset;
        issued = 0;
        got    = 0;
        seen   = '0;
        want   = '0;
        for (int t = 0; t < 22; t++) want[t] = ((t % 11) < 9);
        for (int t = 0; t < 60; t++) begin
            set_op(2, issued + 1, 1);
            req_valid = (t < 22) ? 4'b0100 : 4'b0000;
            #1;
            if (t < 22) seen[t] = (req_ready === 4'b0100);
            if (rsp_valid === 1'b1) begin
                n_tests++;
                if (rsp_id !== 2'd2 || rsp_p !== PW'(got + 1)) begin
                    n_fail++;
                    $display("FAIL c1_rsp%0d: got id=%0d p=%0d want 2/%0d", got, rsp_id, rsp_p, got + 1);
                end
                got++;
            end
            if (req_ready[2] === 1'b1) issued++;
            tick;
        end
        n_tests++;
        if (seen !== want) begin
            n_fail++;
            $display("FAIL c1_pattern: got %b want %b", seen, want);
        end
        n_tests++;
        if (issued !== 18 || got !== 18) begin
            n_fail++;
            $display("FAIL c1_count: got issues=%0d rsp=%0d want 18/18", issued, got);
        end
    endtask

    task automatic test_reset_mid;
        bit stale;
        int waited;
        int accepted;
        int got;
        do_reset;
        set_op(0, 4, 4);
        req_valid = 4'b0001;
        tick;
        tick;
        tick;
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick;
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got ready=%b rsp_valid=%b want 0000/0", req_ready, rsp_valid);
        end
        tick;
        tick;
        reset     = 1'b0;
        req_valid = '0;
        stale     = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (rsp_valid !== 1'b0) stale = 1'b1;
            tick;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL mid_stale: got rsp_valid after reset want none");
        end
        set_op(3, -2, 7);
        req_valid = 4'b1000;
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_grant: got %b want 1000", req_ready);
        end
        tick;
        req_valid = '0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        n_tests++;
        if (waited !== 9 || rsp_id !== 2'd3 || rsp_p !== PW'(-14)) begin
            n_fail++;
            $display("FAIL mid_neg: got wait=%0d id=%0d p=%0h want 9/3/%0h", waited, rsp_id, rsp_p, PW'(-14));
        end
        tick;
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int t = 0; t < 12; t++) begin
            set_op(0, accepted + 1, 1);
            req_valid = 4'b0001;
            #1;
            if (req_ready[0] === 1'b1) accepted++;
            tick;
        end
        req_valid = '0;
        n_tests++;
        if (accepted !== 9) begin
            n_fail++;
            $display("FAIL mid_credit: got accepts=%0d want 9", accepted);
        end
        rsp_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 30; t++) begin
            #1;
            if (rsp_valid === 1'b1) got++;
            tick;
        end
        n_tests++;
        if (got !== 9) begin
            n_fail++;
            $display("FAIL mid_drain: got rsp=%0d want 9", got);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_credit_one;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1);
    end

endmodule
